pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Decides each cycle whether the pipeline advances, which pipeline registers load, and where bubbles or flushes go.
- Covers three hazard sources: split I/D memory handshakes (stall), load-use hazards (one bubble into ID/EX) and EX-stage control redirects (flush IF/ID and ID/EX).
- Works beside the forwarding logic: every hazard forwarding cannot resolve is handled here.
- Keeps saturating performance counters for stall, bubble and flush events.

Parameters:
CNT_WIDTH, 32, width of each performance counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
IFID_rs1  in  5  rs1 of the instruction in ID
IFID_rs2  in  5  rs2 of the instruction in ID
IFID_uses_rs1  in  1  ID instruction reads rs1
IFID_uses_rs2  in  1  ID instruction reads rs2
IDEX_rd  in  5  rd of the instruction in EX
IDEX_mem_read  in  1  EX instruction is a load
EX_redirect  in  1  EX resolved a taken branch or jump (PC mux already selects the target)
imem_read  in  1  fetch request outstanding this cycle
imem_resp  in  1  instruction memory response
dmem_req  in  1  MEM stage has a load or store outstanding
dmem_resp  in  1  data memory response
load_pc  out  1  PC register enable
load_IFID  out  1  IF/ID enable
load_IDEX  out  1  ID/EX enable
load_EXMEM  out  1  EX/MEM enable
load_MEMWB  out  1  MEM/WB enable
IFID_flush  out  1  IF/ID loads a NOP
IDEX_flush  out  1  ID/EX loads a NOP (bubble)
stall_cycles  out  CNT_WIDTH  cycles spent waiting on memory
loaduse_bubbles  out  CNT_WIDTH  load-use bubbles inserted
redirect_flushes  out  CNT_WIDTH  redirect flushes applied

Behaviour:
- State register, two states: RUN and MEM_WAIT.
- Sticky flags imem_done and dmem_done record a response that arrived while the other side is still pending. Memory must not be re-requested.
- mem_ready = (!imem_read | imem_resp | imem_done) & (!dmem_req | dmem_resp | dmem_done).
- Outputs are combinational from state, flags and inputs, so the latency is zero cycles.
- !mem_ready:
  - All load_* = 0; both flush outputs = 0.
  - Set imem_done on imem_resp and dmem_done on dmem_resp.
  - Next state is MEM_WAIT; stall_cycles increments.
- mem_ready (an advance cycle):
  - Both flags clear; next state is RUN.
  - Default: all load_* = 1, no flush.
- Redirect (EX_redirect=1, highest priority):
  - All load_* = 1, IFID_flush = 1, IDEX_flush = 1.
  - No load-use bubble is inserted; redirect_flushes increments.
- Load-use (checked only when there is no redirect):
  - Condition: IDEX_mem_read & IDEX_rd≠0 & ((IFID_uses_rs1 & IFID_rs1==IDEX_rd) | (IFID_uses_rs2 & IFID_rs2==IDEX_rd)).
  - Response: load_pc = 0, load_IFID = 0, load_IDEX = 1 with IDEX_flush = 1, EXMEM/MEMWB load = 1.
  - loaduse_bubbles increments.
- Hazards coinciding with a memory stall:
  - A redirect or load-use raised during a stall is held, because upstream registers are frozen.
  - It is applied on the advance cycle only.
  - A wrong-path fetch in flight is not cancelled: wait for its imem_resp, then flush.
- Simultaneous imem_resp and dmem_resp in the same cycle, with both requested, gives an immediate advance. No MEM_WAIT entry and no counter increment.
- Counters saturate at all-ones and never wrap.
- Reset (asynchronous, any state including MEM_WAIT):
  - State RUN, flags 0, all counters 0.
  - While rst=1, all load_* = 0 and both flushes = 0.
  - First evaluation after deassertion uses RUN with clear flags.

Test Plan:
1. Independent ALU ops, imem_resp=1 each cycle, dmem_req=0 -> all load_*=1, flushes 0, all counters 0 after 10 cycles.
2. IDEX_mem_read=1, IDEX_rd=5, IFID_rs1=5, uses_rs1=1 -> load_pc=0, load_IFID=0, IDEX_flush=1, loaduse_bubbles=1. Repeat with IDEX_rd=0 -> no bubble.
3. imem_read and dmem_req asserted at cycle 0; imem_resp at cycle 3, dmem_resp at cycle 5 -> load_* = 0 for cycles 0-4, imem_done set at cycle 3, advance at cycle 5, stall_cycles=5, state RUN at cycle 6.
4. EX_redirect=1 together with a load-use match -> IFID_flush=1, IDEX_flush=1, load_pc=1, redirect_flushes=1, loaduse_bubbles unchanged.
5. Assert rst in MEM_WAIT with imem_done=1 -> immediate state RUN, flags and counters 0, all load_*=0 while rst is high.
6. CNT_WIDTH=4, hold dmem_req=1 with no dmem_resp for 20 cycles -> stall_cycles reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Bundles the hazard controller's pipeline, memory-handshake and counter signals.
// The controller connects via the slave modport; the pipeline/bench side connects via master.
interface pipeline_hazard_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           IFID_rs1;
    logic [4:0]           IFID_rs2;
    logic                 IFID_uses_rs1;
    logic                 IFID_uses_rs2;
    logic [4:0]           IDEX_rd;
    logic                 IDEX_mem_read;
    logic                 EX_redirect;
    logic                 imem_read;
    logic                 imem_resp;
    logic                 dmem_req;
    logic                 dmem_resp;

    logic                 load_pc;
    logic                 load_IFID;
    logic                 load_IDEX;
    logic                 load_EXMEM;
    logic                 load_MEMWB;
    logic                 IFID_flush;
    logic                 IDEX_flush;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] loaduse_bubbles;
    logic [CNT_WIDTH-1:0] redirect_flushes;

    // Debug view of the sequencer: state (0 = RUN, 1 = MEM_WAIT) and sticky response flags
    logic                 dbg_state;
    logic                 dbg_imem_done;
    logic                 dbg_dmem_done;

    modport slave (
        input  IFID_rs1, IFID_rs2, IFID_uses_rs1, IFID_uses_rs2,
        input  IDEX_rd, IDEX_mem_read, EX_redirect,
        input  imem_read, imem_resp, dmem_req, dmem_resp,
        output load_pc, load_IFID, load_IDEX, load_EXMEM, load_MEMWB,
        output IFID_flush, IDEX_flush,
        output stall_cycles, loaduse_bubbles, redirect_flushes,
        output dbg_state, dbg_imem_done, dbg_dmem_done
    );

    modport master (
        output IFID_rs1, IFID_rs2, IFID_uses_rs1, IFID_uses_rs2,
        output IDEX_rd, IDEX_mem_read, EX_redirect,
        output imem_read, imem_resp, dmem_req, dmem_resp,
        input  load_pc, load_IFID, load_IDEX, load_EXMEM, load_MEMWB,
        input  IFID_flush, IDEX_flush,
        input  stall_cycles, loaduse_bubbles, redirect_flushes,
        input  dbg_state, dbg_imem_done, dbg_dmem_done
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: memory stalls, load-use
// bubbles and EX redirects, with saturating event counters. Outputs are combinational.
module pipeline_hazard_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    pipeline_hazard_controller_if.slave   hz
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 imem_done_q, imem_done_d;
    logic                 dmem_done_q, dmem_done_d;
    logic [CNT_WIDTH-1:0] stall_q, bubble_q, redirect_q;

    logic mem_ready;
    logic load_use;
    logic stall_inc, bubble_inc, redirect_inc;

    // A response seen earlier in this stall counts as ready; memory is never re-requested.
    assign mem_ready = (!hz.imem_read | hz.imem_resp | imem_done_q) &
                       (!hz.dmem_req  | hz.dmem_resp | dmem_done_q);

    assign load_use = hz.IDEX_mem_read & (hz.IDEX_rd != 5'd0) &
                      ((hz.IFID_uses_rs1 & (hz.IFID_rs1 == hz.IDEX_rd)) |
                       (hz.IFID_uses_rs2 & (hz.IFID_rs2 == hz.IDEX_rd)));

    always_comb begin
        state_d       = state_q;
        imem_done_d   = imem_done_q;
        dmem_done_d   = dmem_done_q;
        stall_inc     = 1'b0;
        bubble_inc    = 1'b0;
        redirect_inc  = 1'b0;
        hz.load_pc    = 1'b0;
        hz.load_IFID  = 1'b0;
        hz.load_IDEX  = 1'b0;
        hz.load_EXMEM = 1'b0;
        hz.load_MEMWB = 1'b0;
        hz.IFID_flush = 1'b0;
        hz.IDEX_flush = 1'b0;

        if (!mem_ready) begin
            state_d     = ST_MEM_WAIT;
            imem_done_d = imem_done_q | hz.imem_resp;
            dmem_done_d = dmem_done_q | hz.dmem_resp;
            stall_inc   = 1'b1;
        end else begin
            // Hazards raised during a stall stay visible on the frozen registers until here.
            state_d       = ST_RUN;
            imem_done_d   = 1'b0;
            dmem_done_d   = 1'b0;
            hz.load_pc    = 1'b1;
            hz.load_IFID  = 1'b1;
            hz.load_IDEX  = 1'b1;
            hz.load_EXMEM = 1'b1;
            hz.load_MEMWB = 1'b1;
            if (hz.EX_redirect) begin
                hz.IFID_flush = 1'b1;
                hz.IDEX_flush = 1'b1;
                redirect_inc  = 1'b1;
            end else if (load_use) begin
                hz.load_pc    = 1'b0;
                hz.load_IFID  = 1'b0;
                hz.IDEX_flush = 1'b1;
                bubble_inc    = 1'b1;
            end
        end

        if (rst) begin
            hz.load_pc    = 1'b0;
            hz.load_IFID  = 1'b0;
            hz.load_IDEX  = 1'b0;
            hz.load_EXMEM = 1'b0;
            hz.load_MEMWB = 1'b0;
            hz.IFID_flush = 1'b0;
            hz.IDEX_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q    <= '0;
            bubble_q   <= '0;
            redirect_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (bubble_inc && (bubble_q != '1))
                bubble_q <= bubble_q + 1'b1;
            if (redirect_inc && (redirect_q != '1))
                redirect_q <= redirect_q + 1'b1;
        end
    end

    assign hz.stall_cycles     = stall_q;
    assign hz.loaduse_bubbles  = bubble_q;
    assign hz.redirect_flushes = redirect_q;
    assign hz.dbg_state        = state_q;
    assign hz.dbg_imem_done    = imem_done_q;
    assign hz.dbg_dmem_done    = dmem_done_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a 32-bit counter instance for the main
// sequence and a 4-bit counter instance for saturation.
module tb_pipeline_hazard_controller;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_hazard_controller_if #(.CNT_WIDTH(32)) hz ();
    pipeline_hazard_controller_if #(.CNT_WIDTH(4))  hz4 ();

    pipeline_hazard_controller #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    pipeline_hazard_controller #(.CNT_WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .hz  (hz4)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Order: load_pc, load_IFID, load_IDEX, load_EXMEM, load_MEMWB, IFID_flush, IDEX_flush
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, hz.load_pc, hz.load_IFID, hz.load_IDEX, hz.load_EXMEM,
                  hz.load_MEMWB, hz.IFID_flush, hz.IDEX_flush}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.IFID_rs1      = 5'd1;
        hz.IFID_rs2      = 5'd2;
        hz.IFID_uses_rs1 = 1'b1;
        hz.IFID_uses_rs2 = 1'b1;
        hz.IDEX_rd       = 5'd3;
        hz.IDEX_mem_read = 1'b0;
        hz.EX_redirect   = 1'b0;
        hz.imem_read     = 1'b1;
        hz.imem_resp     = 1'b1;
        hz.dmem_req      = 1'b0;
        hz.dmem_resp     = 1'b0;
    endtask

    localparam logic [6:0] CTL_RUN    = 7'b1111100;
    localparam logic [6:0] CTL_STALL  = 7'b0000000;
    localparam logic [6:0] CTL_BUBBLE = 7'b0011101;
    localparam logic [6:0] CTL_REDIR  = 7'b1111111;

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        hz4.IFID_rs1 = 5'd0; hz4.IFID_rs2 = 5'd0;
        hz4.IFID_uses_rs1 = 1'b0; hz4.IFID_uses_rs2 = 1'b0;
        hz4.IDEX_rd = 5'd0; hz4.IDEX_mem_read = 1'b0; hz4.EX_redirect = 1'b0;
        hz4.imem_read = 1'b0; hz4.imem_resp = 1'b0;
        hz4.dmem_req = 1'b0; hz4.dmem_resp = 1'b0;

        #2;
        chk_ctl("reset_ctl", CTL_STALL);
        chk("reset_state", {31'd0, hz.dbg_state}, 32'd0);
        chk("reset_stall", hz.stall_cycles, 32'd0);
        chk("reset_bubbles", hz.loaduse_bubbles, 32'd0);
        chk("reset_redirects", hz.redirect_flushes, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Independent ALU ops, fetch answers every cycle
        for (int c = 0; c < 10; c++) begin
            #1;
            chk_ctl($sformatf("alu_ctl_c%0d", c), CTL_RUN);
            tick();
        end
        chk("alu_stall", hz.stall_cycles, 32'd0);
        chk("alu_bubbles", hz.loaduse_bubbles, 32'd0);
        chk("alu_redirects", hz.redirect_flushes, 32'd0);

        // Load-use on rs1
        hz.IDEX_mem_read = 1'b1; hz.IDEX_rd = 5'd5; hz.IFID_rs1 = 5'd5;
        #1;
        chk_ctl("lu_rs1_ctl", CTL_BUBBLE);
        tick();
        chk("lu_rs1_bubbles", hz.loaduse_bubbles, 32'd1);

        // Load to x0 never creates a hazard
        hz.IDEX_rd = 5'd0; hz.IFID_rs1 = 5'd0;
        #1;
        chk_ctl("lu_x0_ctl", CTL_RUN);
        tick();
        chk("lu_x0_bubbles", hz.loaduse_bubbles, 32'd1);

        // Load-use on rs2
        hz.IFID_uses_rs1 = 1'b0; hz.IDEX_rd = 5'd7; hz.IFID_rs2 = 5'd7; hz.IFID_rs1 = 5'd7;
        #1;
        chk_ctl("lu_rs2_ctl", CTL_BUBBLE);
        tick();
        chk("lu_rs2_bubbles", hz.loaduse_bubbles, 32'd2);

        // Register match but the operand is not read
        hz.IFID_uses_rs2 = 1'b0;
        #1;
        chk_ctl("lu_unused_ctl", CTL_RUN);
        tick();
        chk("lu_unused_bubbles", hz.loaduse_bubbles, 32'd2);
        idle_inputs();

        // Split memory stall: imem answers at cycle 3, dmem at cycle 5
        hz.imem_resp = 1'b0; hz.dmem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_ctl($sformatf("mw_ctl_c%0d", c), CTL_STALL);
            tick();
        end
        chk("mw_state_c3", {31'd0, hz.dbg_state}, 32'd1);
        hz.imem_resp = 1'b1;
        #1;
        chk_ctl("mw_ctl_c3", CTL_STALL);
        tick();
        chk("mw_imem_done", {31'd0, hz.dbg_imem_done}, 32'd1);
        hz.imem_resp = 1'b0;
        #1;
        chk_ctl("mw_ctl_c4", CTL_STALL);
        tick();
        hz.dmem_resp = 1'b1;
        #1;
        chk_ctl("mw_advance_ctl", CTL_RUN);
        tick();
        chk("mw_state_c6", {31'd0, hz.dbg_state}, 32'd0);
        chk("mw_imem_done_clr", {31'd0, hz.dbg_imem_done}, 32'd0);
        chk("mw_stall", hz.stall_cycles, 32'd5);
        idle_inputs();

        // Simultaneous responses advance at once
        hz.dmem_req = 1'b1; hz.dmem_resp = 1'b1;
        #1;
        chk_ctl("both_resp_ctl", CTL_RUN);
        tick();
        chk("both_resp_state", {31'd0, hz.dbg_state}, 32'd0);
        chk("both_resp_stall", hz.stall_cycles, 32'd5);
        idle_inputs();

        // Redirect beats a coincident load-use
        hz.EX_redirect = 1'b1; hz.IDEX_mem_read = 1'b1; hz.IDEX_rd = 5'd1;
        #1;
        chk_ctl("redir_lu_ctl", CTL_REDIR);
        tick();
        chk("redir_count", hz.redirect_flushes, 32'd1);
        chk("redir_bubbles", hz.loaduse_bubbles, 32'd2);
        idle_inputs();

        // Redirect during a data stall is held until the advance cycle
        hz.EX_redirect = 1'b1; hz.dmem_req = 1'b1;
        #1;
        chk_ctl("held_redir_stall_ctl", CTL_STALL);
        tick();
        chk("held_redir_count0", hz.redirect_flushes, 32'd1);
        hz.dmem_resp = 1'b1;
        #1;
        chk_ctl("held_redir_adv_ctl", CTL_REDIR);
        tick();
        chk("held_redir_count1", hz.redirect_flushes, 32'd2);
        chk("held_redir_stall", hz.stall_cycles, 32'd6);
        idle_inputs();

        // Asynchronous reset while waiting with imem_done set
        hz.dmem_req = 1'b1;
        tick();
        chk("pre_rst_state", {31'd0, hz.dbg_state}, 32'd1);
        chk("pre_rst_imem_done", {31'd0, hz.dbg_imem_done}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_state", {31'd0, hz.dbg_state}, 32'd0);
        chk("rst_imem_done", {31'd0, hz.dbg_imem_done}, 32'd0);
        chk("rst_stall", hz.stall_cycles, 32'd0);
        chk("rst_redirects", hz.redirect_flushes, 32'd0);
        chk("rst_bubbles", hz.loaduse_bubbles, 32'd0);
        chk_ctl("rst_ctl", CTL_STALL);
        tick();
        chk_ctl("rst_ctl_held", CTL_STALL);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_ctl("post_rst_ctl", CTL_RUN);
        tick();

        // Saturation on the 4-bit instance
        hz4.dmem_req = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        chk("sat_stall_15", {28'd0, hz4.stall_cycles}, 32'd15);
        for (int c = 0; c < 5; c++) tick();
        chk("sat_stall_held", {28'd0, hz4.stall_cycles}, 32'd15);
        chk("sat_state", {31'd0, hz4.dbg_state}, 32'd1);
        hz4.dmem_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
